tff_counter: RTL and testbench

Parametrised successor to the single-bit toggle flip-flop: a WIDTH-bit register that runs either as a bank of independent T flip-flops or as a modulo-MODULUS up/down counter. It also provides a registered wrap pulse and a divided-clock output that toggles once per wrap. It serves as the general counting and toggling primitive for dividers, event counters and blink/LED logic in the design.

---
 rtl/tff_counter.sv | 109 ++++++++++
 tb/tb_tff_counter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/tff_counter.sv
// tff_counter: WIDTH-bit register acting as a modulo-MODULUS up/down counter
// (mode=0) or as a bank of independent T flip-flops (mode=1).
// Latency: one cycle from any input to q/wrap/div_out; all outputs registered.
// Backpressure: none; en gates counting/toggling, clr/load take effect unconditionally.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous reset, active-low; clears q, wrap and div_out
//   clr       synchronous clear of q (and wrap); div_out holds
//   load      synchronous load of load_val (clamped to MODULUS-1 in counter mode)
//   load_val  value to load
//   en        count/toggle enable
//   mode      0 = modulo counter, 1 = toggle bank
//   up        counter direction: 1 = up, 0 = down
//   t         per-bit toggle enables (toggle mode only)
//   q         register value
//   wrap      one-cycle pulse in the cycle after a counter wrap
//   div_out   toggles once per wrap (period 2*MODULUS enabled cycles)
module tff_counter #(
    parameter int unsigned     WIDTH   = 8,
    parameter longint unsigned MODULUS = 64'(1) << WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             mode,
    input  logic             up,
    input  logic [WIDTH-1:0] t,
    output logic [WIDTH-1:0] q,
    output logic             wrap,
    output logic             div_out
);

    // Terminal count. MODULUS is carried at 64 bits so that the default
    // 2**WIDTH stays representable for WIDTH=32; MODULUS-1 always fits in WIDTH.
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MODULUS - 64'd1);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] q_q, q_d;
    logic             wrap_q, wrap_d;
    logic             div_q, div_d;
    logic             wrap_evt;

    // Next-state: clr > load > en. Every branch drives wrap low except a
    // genuine counter wrap, so clr/load/idle/toggle all suppress the pulse.
    always_comb begin
        q_d      = q_q;
        wrap_evt = 1'b0;

        if (clr) begin
            q_d = '0;
        end else if (load) begin
            // Clamp only in counter mode so the counter never holds an
            // out-of-range value; toggle mode uses the full register.
            if (!mode && (load_val > MAX_V)) begin
                q_d = MAX_V;
            end else begin
                q_d = load_val;
            end
        end else if (en) begin
            if (mode) begin
                q_d = q_q ^ t;
            end else if (up) begin
                // ">=" also catches values above MAX_V left over from toggle mode.
                if (q_q >= MAX_V) begin
                    q_d      = '0;
                    wrap_evt = 1'b1;
                end else begin
                    q_d = q_q + ONE;
                end
            end else begin
                if (q_q == '0) begin
                    q_d      = MAX_V;
                    wrap_evt = 1'b1;
                end else if (q_q > MAX_V) begin
                    // Out-of-range value from toggle mode: snap into range,
                    // which is not counted as a wrap.
                    q_d = MAX_V;
                end else begin
                    q_d = q_q - ONE;
                end
            end
        end

        wrap_d = wrap_evt;
        div_d  = wrap_evt ? ~div_q : div_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            q_q    <= '0;
            wrap_q <= 1'b0;
            div_q  <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
            div_q  <= div_d;
        end
    end

    assign q       = q_q;
    assign wrap    = wrap_q;
    assign div_out = div_q;

endmodule

// File: tb/tb_tff_counter.sv
// tb_tff_counter: checks three tff_counter instances (W4/M10, W1/M2, W8/M256)
// against a cycle-level integer model, with directed scenarios then random traffic.
// Control inputs are shared; load_val/t are sliced per instance width.
module tb_tff_counter;

    logic       clk;
    logic       rst, clr, load, en, mode, up;
    logic [7:0] lv, tv;

    logic [3:0] q4;
    logic       w4, d4;
    logic [0:0] q1;
    logic       w1, d1;
    logic [7:0] q8;
    logic       w8, d8;

    int n_tests;
    int n_fail;

    // Model state per instance: 0 = W4/M10, 1 = W1/M2, 2 = W8/M256.
    int mq[3];
    int mw[3];
    int md[3];

    tff_counter #(.WIDTH(4), .MODULUS(10)) u_w4 (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(lv[3:0]),
        .en(en), .mode(mode), .up(up), .t(tv[3:0]),
        .q(q4), .wrap(w4), .div_out(d4)
    );

    tff_counter #(.WIDTH(1), .MODULUS(2)) u_w1 (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(lv[0:0]),
        .en(en), .mode(mode), .up(up), .t(tv[0:0]),
        .q(q1), .wrap(w1), .div_out(d1)
    );

    tff_counter #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(lv),
        .en(en), .mode(mode), .up(up), .t(tv),
        .q(q8), .wrap(w8), .div_out(d8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Behavioural model of one edge, written from the operating rules with
    // plain integer arithmetic.
    task automatic model_step(input int w, input int m, inout int q,
                              inout int wr, inout int dv);
        int mask;
        int l;
        int tt;
        mask = (1 << w) - 1;
        l    = int'(lv) & mask;
        tt   = int'(tv) & mask;
        wr   = 0;
        if (!rst) begin
            q  = 0;
            dv = 0;
        end else if (clr) begin
            q = 0;
        end else if (load) begin
            q = (!mode && l > m - 1) ? m - 1 : l;
        end else if (en) begin
            if (mode) begin
                q = q ^ tt;
            end else if (up) begin
                if (q >= m - 1) begin
                    q = 0; wr = 1; dv = 1 - dv;
                end else begin
                    q = q + 1;
                end
            end else begin
                if (q == 0) begin
                    q = m - 1; wr = 1; dv = 1 - dv;
                end else if (q > m - 1) begin
                    q = m - 1;
                end else begin
                    q = q - 1;
                end
            end
        end
    endtask

    // One clock edge: advance the model with the inputs seen at the edge,
    // then compare every output of every instance just after the edge.
    task automatic cycle();
        @(posedge clk);
        model_step(4, 10,  mq[0], mw[0], md[0]);
        model_step(1, 2,   mq[1], mw[1], md[1]);
        model_step(8, 256, mq[2], mw[2], md[2]);
        #1;
        check("q4",   int'(q4), mq[0]);
        check("wrap4", int'(w4), mw[0]);
        check("div4", int'(d4), md[0]);
        check("q1",   int'(q1), mq[1]);
        check("wrap1", int'(w1), mw[1]);
        check("div1", int'(d1), md[1]);
        check("q8",   int'(q8), mq[2]);
        check("wrap8", int'(w8), mw[2]);
        check("div8", int'(d8), md[2]);
    endtask

    task automatic idle_inputs();
        rst = 1'b1; clr = 1'b0; load = 1'b0; en = 1'b0;
        mode = 1'b0; up = 1'b1; lv = 8'd0; tv = 8'd0;
    endtask

    initial begin
        int wraps;
        int div_before;
        int exp_dn[5];
        int exp_dw[5];

        n_tests = 0;
        n_fail  = 0;
        for (int i = 0; i < 3; i++) begin
            mq[i] = 0; mw[i] = 0; md[i] = 0;
        end

        // Reset held for two cycles while enabled.
        idle_inputs();
        rst = 1'b0; en = 1'b1; up = 1'b1;
        #1;
        cycle();
        cycle();
        check("rst_q",    int'(q4), 0);
        check("rst_wrap", int'(w4), 0);
        check("rst_div",  int'(d4), 0);

        // Release: counting starts on the very next edge.
        rst = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            cycle();
            check("post_rst_q", int'(q4), i);
        end

        // Up wrap: 25 enabled cycles from 0 contain exactly two wraps.
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        wraps = 0;
        for (int i = 1; i <= 25; i++) begin
            cycle();
            if (w4) wraps++;
            if (i == 10 || i == 20) check("wrap_at_zero", int'(w4), 1);
        end
        check("wrap_count", wraps, 2);
        check("div_after_2wraps", int'(d4), 0);

        // Down wrap from a loaded 3.
        load = 1'b1; lv = 8'd3; mode = 1'b0;
        cycle();
        load = 1'b0; up = 1'b0; en = 1'b1;
        exp_dn = '{2, 1, 0, 9, 8};
        exp_dw = '{0, 0, 0, 1, 0};
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("down_q",    int'(q4), exp_dn[i]);
            check("down_wrap", int'(w4), exp_dw[i]);
        end

        // Load clamp in counter mode.
        load = 1'b1; lv = 8'd13;
        cycle();
        check("clamp_q", int'(q4), 9);

        // Toggle mode: load 0101, t = 0011 twice.
        mode = 1'b1; lv = 8'b0101; tv = 8'b0011;
        cycle();
        load = 1'b0; en = 1'b1;
        cycle();
        check("tog_q1", int'(q4), 4'b0110);
        cycle();
        check("tog_q2", int'(q4), 4'b0101);
        check("tog_wrap", int'(w4), 0);

        // Out-of-range value from toggle mode, then count down: snap to 9, no wrap.
        load = 1'b1; lv = 8'b1110;
        cycle();
        check("tog_load", int'(q4), 14);
        load = 1'b0; mode = 1'b0; up = 1'b0;
        cycle();
        check("snap_q",    int'(q4), 9);
        check("snap_wrap", int'(w4), 0);

        // Collision: clr beats load and en at q=9 counting up.
        div_before = int'(d4);
        clr = 1'b1; load = 1'b1; lv = 8'd5; en = 1'b1; up = 1'b1;
        cycle();
        check("clr_q",    int'(q4), 0);
        check("clr_wrap", int'(w4), 0);
        check("clr_div",  int'(d4), div_before);

        // load beats en.
        clr = 1'b0; load = 1'b1; lv = 8'd7;
        cycle();
        check("load_en_q", int'(q4), 7);

        // WIDTH=1 toggle bank behaves as a plain T flip-flop.
        load = 1'b0; mode = 1'b1; tv = 8'hFF; en = 1'b1;
        for (int i = 0; i < 4; i++) cycle();

        // WIDTH=8 wraps 255 -> 0 with a pulse.
        mode = 1'b0; load = 1'b1; lv = 8'd254; up = 1'b1;
        cycle();
        load = 1'b0;
        cycle();
        check("w8_255", int'(q8), 255);
        cycle();
        check("w8_wrap_q", int'(q8), 0);
        check("w8_wrap",   int'(w8), 1);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rst  = ($urandom_range(0, 99) >= 2);
            clr  = ($urandom_range(0, 99) < 3);
            load = ($urandom_range(0, 99) < 6);
            en   = ($urandom_range(0, 99) < 85);
            mode = ($urandom_range(0, 99) < 25);
            up   = ($urandom_range(0, 99) < 60);
            lv   = 8'($urandom);
            tv   = 8'($urandom);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
